// File: rtl/stepper_pkg.sv
// Shared types and defaults for the step/dir move sequencer.
//   seq_state_t : sequencer FSM states
//   move_cmd_t  : buffered move command {dir, steps, period}
package stepper_pkg;

    localparam int unsigned CMD_STEP_W          = 32;
    localparam int unsigned CMD_TICK_W          = 16;
    localparam int unsigned DEF_PULSE_TICKS     = 4;
    localparam int unsigned DEF_DIR_SETUP_TICKS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_SETUP = 2'd1,
        PULSE_HI  = 2'd2,
        PULSE_LO  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic                  dir;
        logic [CMD_STEP_W-1:0] steps;
        logic [CMD_TICK_W-1:0] period;
    } move_cmd_t;

endpackage

// File: rtl/move_cmd_buffer.sv
// One-entry valid/ready holding register for a pending move command.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : drop any held command
//   in_valid_i/in_ready_o/in_cmd_i : write side (ready while empty)
//   out_valid_o/out_cmd_o/pop_i    : read side (pop frees the entry)
module move_cmd_buffer
    import stepper_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    input  logic      in_valid_i,
    output logic      in_ready_o,
    input  move_cmd_t in_cmd_i,
    output logic      out_valid_o,
    output move_cmd_t out_cmd_o,
    input  logic      pop_i
);

    logic      valid_q, valid_d;
    move_cmd_t cmd_q, cmd_d;

    // Flush wins; a write only lands in an empty slot, so push and pop never coincide.
    always_comb begin
        valid_d = valid_q;
        cmd_d   = cmd_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_valid_i && !valid_q) begin
            valid_d = 1'b1;
            cmd_d   = in_cmd_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
        end
    end

    assign in_ready_o  = !valid_q;
    assign out_valid_o = valid_q;
    assign out_cmd_o   = cmd_q;

endmodule

// File: rtl/step_sequencer.sv
// Move-command sequencer driving step/dir of a stepper phase driver.
//   CLK, reset           : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready = pending slot empty, no abort/reset)
//   cmd_dir/steps/period : move direction, step count (0 = null move), step period
//   abort                : cancel active and pending moves
//   step, dir            : outputs to the stepper
//   busy, move_done      : activity flag, one-cycle completion pulse
//   steps_left           : steps remaining in the active move
// STEP_W/TICK_W must not exceed the package command field widths.
module step_sequencer
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_W          = CMD_STEP_W,
    parameter int unsigned TICK_W          = CMD_TICK_W,
    parameter int unsigned PULSE_TICKS     = DEF_PULSE_TICKS,
    parameter int unsigned DIR_SETUP_TICKS = DEF_DIR_SETUP_TICKS
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [TICK_W-1:0] cmd_period,
    input  logic              abort,
    output logic              step,
    output logic              dir,
    output logic              busy,
    output logic              move_done,
    output logic [STEP_W-1:0] steps_left
);

    localparam logic [TICK_W-1:0] HI_LOAD    = TICK_W'(PULSE_TICKS - 1);
    localparam logic [TICK_W-1:0] SETUP_LOAD = TICK_W'(DIR_SETUP_TICKS - 1);
    // Minimum effective period; also the bias that turns eff into a low-phase count load.
    localparam logic [TICK_W-1:0] MIN_EFF    = TICK_W'(PULSE_TICKS + 1);

    seq_state_t        state_q, state_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [TICK_W-1:0] eff_q, eff_d;
    logic [STEP_W-1:0] left_q, left_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              done_q, done_d;
    logic              load, take;

    logic              buf_ready, pend_valid;
    move_cmd_t         in_cmd, pend_cmd;
    logic              p_dir;
    logic [STEP_W-1:0] p_steps;
    logic [TICK_W-1:0] p_period, p_eff;

    assign cmd_ready     = buf_ready & ~abort & ~reset;
    assign in_cmd.dir    = cmd_dir;
    assign in_cmd.steps  = CMD_STEP_W'(cmd_steps);
    assign in_cmd.period = CMD_TICK_W'(cmd_period);

    move_cmd_buffer u_pending (
        .clk_i       (CLK),
        .rst_i       (reset),
        .flush_i     (abort),
        .in_valid_i  (cmd_valid & cmd_ready),
        .in_ready_o  (buf_ready),
        .in_cmd_i    (in_cmd),
        .out_valid_o (pend_valid),
        .out_cmd_o   (pend_cmd),
        .pop_i       (load)
    );

    assign p_dir    = pend_cmd.dir;
    assign p_steps  = STEP_W'(pend_cmd.steps);
    assign p_period = TICK_W'(pend_cmd.period);
    assign p_eff    = (p_period > MIN_EFF) ? p_period : MIN_EFF;

    // Next-state / output logic; one down-counter times setup, high and low phases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eff_d   = eff_q;
        left_d  = left_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        load    = 1'b0;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_valid) begin
                    load = 1'b1;
                    if (p_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            DIR_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE_HI;
                    cnt_d   = HI_LOAD;
                    if (left_q != '0) begin
                        left_d = left_q - STEP_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - TICK_W'(1);
                end
            end
            PULSE_HI: begin
                if (cnt_q == '0) begin
                    state_d = PULSE_LO;
                    cnt_d   = eff_q - MIN_EFF;
                end else begin
                    cnt_d = cnt_q - TICK_W'(1);
                end
            end
            PULSE_LO: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - TICK_W'(1);
                end else if (left_q != '0) begin
                    state_d = PULSE_HI;
                    cnt_d   = HI_LOAD;
                    left_d  = left_q - STEP_W'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    // Chain a queued nonzero move; a queued null move is retired from IDLE.
                    if (pend_valid && (p_steps != '0)) begin
                        load = 1'b1;
                        take = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Launch the loaded move, inserting setup time on a direction change.
        if (take) begin
            eff_d = p_eff;
            if (p_dir != dir_q) begin
                dir_d   = p_dir;
                state_d = DIR_SETUP;
                cnt_d   = SETUP_LOAD;
                left_d  = p_steps;
            end else begin
                state_d = PULSE_HI;
                cnt_d   = HI_LOAD;
                left_d  = p_steps - STEP_W'(1);
            end
        end

        // Abort overrides everything but leaves dir untouched.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            left_d  = '0;
            dir_d   = dir_q;
            done_d  = 1'b0;
            load    = 1'b0;
        end

        step_d = (state_d == PULSE_HI);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            eff_q   <= '0;
            left_q  <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eff_q   <= eff_d;
            left_q  <= left_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign move_done  = done_q;
    assign steps_left = left_q;
    assign busy       = (state_q != IDLE) | pend_valid;

endmodule
